// File: rtl/button_pkg.sv
// Shared types and helpers for the front-panel button event controller.
package button_pkg;
  localparam int TICK_MAX_DEFAULT   = 249999;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int N_BTN_DEFAULT      = 4;
  localparam int BTN_ID_W           = $clog2(N_BTN_DEFAULT);

  typedef logic [BTN_ID_W-1:0] btn_id_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/evt_fifo.sv
// Show-ahead event FIFO; head word is presented while count is non-zero.
module evt_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  assign do_pop  = valid & ready;
  assign do_push = push & (count != CW'(DEPTH));
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/button_event_ctrl.sv
// Shared-prescaler button debounce, press-edge detect and round-robin
// arbitration of press events into a small show-ahead FIFO.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_MAX   = TICK_MAX_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int ID_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic             o_evt_valid,
  output logic [ID_W-1:0]  o_evt_id,
  input  logic             i_evt_ready,
  output logic [N_BTN-1:0] o_btn_level,
  output logic             o_overflow
);
  localparam int CNT_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] presc;
  logic             tick, tick_d;
  logic [N_BTN-1:0] sync1, sync2, q0, q1, q2;
  logic [N_BTN-1:0] press, pend, gnt_mask;
  logic [ID_W-1:0]  rr_ptr, gnt_id;
  logic             gnt_vld, overflow;
  logic [FCW-1:0]   fifo_count;
  int               j;

  assign tick  = (presc == CNT_W'(TICK_MAX));
  assign press = {N_BTN{tick_d}} & q1 & ~q2;

  // First pending channel at or after rr_ptr; nothing granted while full.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_mask = '0;
    j        = 0;
    if (fifo_count != FCW'(FIFO_DEPTH)) begin
      for (int k = 0; k < N_BTN; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= N_BTN) j = j - N_BTN;
        if (!gnt_vld && pend[ID_W'(j)]) begin
          gnt_vld = 1'b1;
          gnt_id  = ID_W'(j);
        end
      end
    end
    if (gnt_vld) gnt_mask[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      tick_d   <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
      q0       <= '0;
      q1       <= '0;
      q2       <= '0;
      pend     <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      presc  <= tick ? '0 : presc + 1'b1;
      tick_d <= tick;
      sync1  <= i_btn;
      sync2  <= sync1;
      if (tick) begin
        q0 <= sync2;
        q1 <= q0;
        q2 <= q1;
      end
      // A new press beats the same-cycle grant so the channel stays pending.
      pend     <= (pend & ~gnt_mask) | press;
      overflow <= |(press & pend & ~gnt_mask);
      if (gnt_vld) rr_ptr <= ID_W'(rr_next(int'(gnt_id), N_BTN));
    end
  end

  evt_fifo #(.W(ID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_vld),
    .din   (gnt_id),
    .ready (i_evt_ready),
    .valid (o_evt_valid),
    .dout  (o_evt_id),
    .count (fifo_count)
  );

  assign o_btn_level = q1;
  assign o_overflow  = overflow;
endmodule
